// File: rtl/mult_issue_queue.sv
// Operand FIFO and issue sequencer in front of a shift/add multiplier: issues pairs, waits LATENCY, presents product.
// Optional MULT_ISSUE_STAT_EN adds an 8-bit completed-handshake counter port op_count.
module mult_issue_queue #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 mul_start,
  output logic                 mul_en,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data
`ifdef MULT_ISSUE_STAT_EN
  ,
  output logic [7:0]           op_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_mem_a [DEPTH];
  logic [WIDTH-1:0]   r_mem_b [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_cnt;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_out_valid;
  logic [PW-1:0]      r_out_data;
  logic               w_push;
  logic               w_pop;
  logic               w_capture;

  // in_ready comes from the registered count only, so a pop never frees a slot in the same cycle
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign w_push    = in_valid && in_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !r_out_valid;
  assign w_capture = (r_state == S_WAIT) && (r_cnt == 8'd0);

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (w_capture) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mul_start = 1'b0;
    mul_en    = 1'b0;
    case (r_state)
      S_ISSUE: begin
        mul_start = 1'b1;
        mul_en    = 1'b1;
      end
      S_WAIT:  mul_en = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_cnt       <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_pop) begin
        r_mul_a <= r_mem_a[r_rd_ptr];
        r_mul_b <= r_mem_b[r_rd_ptr];
      end
      if (r_state == S_ISSUE)
        r_cnt <= 8'(LATENCY - 1);
      else if ((r_state == S_WAIT) && (r_cnt != 8'd0))
        r_cnt <= r_cnt - 8'd1;
      if (w_capture) begin
        r_out_data  <= mul_product;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_ISSUE_STAT_EN
  logic [7:0] r_op_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_op_count <= 8'd0;
    else if (r_out_valid && out_ready) r_op_count <= r_op_count + 8'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue with a behavioural LATENCY-cycle multiplier datapath.
module tb_mult_issue_queue;

  localparam int unsigned LAT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic       mul_start;
  logic       mul_en;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_product = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
`ifdef MULT_ISSUE_STAT_EN
  logic [7:0] op_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int m_cnt   = 0;

  mult_issue_queue #(.WIDTH(4), .DEPTH(4), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MULT_ISSUE_STAT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  // Datapath model: product is garbage after start and becomes a*b LAT cycles after the start cycle
  always @(posedge clk) begin
    if (mul_start) begin
      m_cnt       <= 1;
      mul_product <= 8'hEE;
    end else if (m_cnt != 0 && m_cnt < int'(LAT)) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == int'(LAT) - 1) mul_product <= {4'd0, mul_a} * {4'd0, mul_b};
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({in_ready, mul_start, mul_en, out_valid} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL reset_ctrl got %b want 1000", {in_ready, mul_start, mul_en, out_valid});
    end
    vec_cnt++;
    if ({mul_a, mul_b, out_data} !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_data got %h want 0000", {mul_a, mul_b, out_data});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int k = 0;
    int starts = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 4'd13; in_b = 4'd11;
    @(negedge clk);
    in_valid = 1'b0;
    vec_cnt++;
    if (mul_start !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_no_same_cycle_pop got %b want 0", mul_start);
    end
    @(negedge clk);
    vec_cnt++;
    if ({mul_start, mul_en, mul_a, mul_b} !== {1'b1, 1'b1, 4'd13, 4'd11}) begin
      err_cnt++;
      $display("FAIL single_issue got %b want 1111011011", {mul_start, mul_en, mul_a, mul_b});
    end
    while (out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
      if (mul_start === 1'b1) starts++;
    end
    vec_cnt++;
    if (k != 7) begin
      err_cnt++;
      $display("FAIL single_latency got %0d want 7", k);
    end
    vec_cnt++;
    if (out_data !== 8'd143) begin
      err_cnt++;
      $display("FAIL single_data got %0d want 143", out_data);
    end
    vec_cnt++;
    if (starts != 0) begin
      err_cnt++;
      $display("FAIL single_start_width got %0d extra starts want 0", starts);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_consume got %b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  // Covers FIFO fill, output backpressure and release with in-order drain
  task automatic test_fill();
    logic [3:0] fa [6];
    logic [3:0] fb [6];
    logic [7:0] fp [6];
    int idx = 0;
    int got = 0;
    int first_block = -1;
    int dup = 0;
    fa = '{4'd13, 4'd15, 4'd0, 4'd7, 4'd1, 4'd9};
    fb = '{4'd11, 4'd15, 4'd9, 4'd3, 4'd14, 4'd12};
    fp = '{8'd143, 8'd225, 8'd0, 8'd21, 8'd14, 8'd108};
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = fa[idx]; in_b = fb[idx];
      #1;
      if (in_ready === 1'b1) idx++;
      else if (first_block < 0) first_block = c;
    end
    vec_cnt++;
    if (first_block != 5 || idx != 5) begin
      err_cnt++;
      $display("FAIL fill_full got block=%0d accepted=%0d want block=5 accepted=5", first_block, idx);
    end
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== fp[0]) begin
      err_cnt++;
      $display("FAIL fill_first_result got v=%b d=%0d want v=1 d=143", out_valid, out_data);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vec_cnt++;
      if ({out_valid, mul_start, in_ready, out_data} !== {3'b100, 8'd143}) begin
        err_cnt++;
        $display("FAIL backpressure_hold c=%0d got %b want 10010001111", c, {out_valid, mul_start, in_ready, out_data});
      end
    end
    for (int c = 0; c < 150 && got < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (idx < 6);
      if (idx < 6) begin in_a = fa[idx]; in_b = fb[idx]; end
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        vec_cnt++;
        if (out_data !== fp[got]) begin
          err_cnt++;
          $display("FAIL drain_order idx=%0d got %0d want %0d", got, out_data, fp[got]);
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    vec_cnt++;
    if (got != 6 || idx != 6) begin
      err_cnt++;
      $display("FAIL drain_count got results=%0d accepted=%0d want 6 and 6", got, idx);
    end
    repeat (12) begin
      @(negedge clk);
      if (out_valid === 1'b1 || mul_start === 1'b1) dup++;
    end
    vec_cnt++;
    if (dup != 0) begin
      err_cnt++;
      $display("FAIL drain_duplicate got %0d extra events want 0", dup);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [3:0] sa [8];
    logic [3:0] sb [8];
    logic [7:0] exp_q [$];
    logic [7:0] want;
    int idx = 0;
    int got = 0;
    for (int i = 0; i < 8; i++) begin
      sa[i] = 4'($urandom_range(0, 15));
      sb[i] = 4'($urandom_range(0, 15));
    end
    for (int c = 0; c < 600 && got < 8; c++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (idx < 8);
      if (idx < 8) begin in_a = sa[idx]; in_b = sb[idx]; end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back({4'd0, sa[idx]} * {4'd0, sb[idx]});
        idx++;
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        vec_cnt++;
        if (out_data !== want) begin
          err_cnt++;
          $display("FAIL stream_result idx=%0d got %0d want %0d", got, out_data, want);
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    vec_cnt++;
    if (got != 8) begin
      err_cnt++;
      $display("FAIL stream_count got %0d want 8", got);
    end
  endtask

  task automatic test_reset_midop();
    int idx = 0;
    int stale = 0;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 4'(idx + 2); in_b = 4'd5;
      #1;
      if (in_ready === 1'b1) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vec_cnt++;
    if ({mul_en, mul_start, in_ready} !== 3'b100) begin
      err_cnt++;
      $display("FAIL midop_pre_reset got %b want 100", {mul_en, mul_start, in_ready});
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({mul_en, out_valid, in_ready, mul_a} !== {3'b001, 4'd0}) begin
      err_cnt++;
      $display("FAIL midop_async_reset got %b want 0010000", {mul_en, out_valid, in_ready, mul_a});
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1 || mul_start === 1'b1) stale++;
    end
    vec_cnt++;
    if (stale != 0) begin
      err_cnt++;
      $display("FAIL midop_stale got %0d events want 0", stale);
    end
    out_ready = 1'b0;
  endtask

`ifdef MULT_ISSUE_STAT_EN
  task automatic test_stat();
    int hs = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++;
    if (op_count !== 8'd0) begin
      err_cnt++;
      $display("FAIL stat_reset got %0d want 0", op_count);
    end
    for (int c = 0; c < 4000 && hs < 257; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5;
      #1;
      if (out_valid && out_ready) hs++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    vec_cnt++;
    if (op_count !== 8'd1 || hs != 257) begin
      err_cnt++;
      $display("FAIL stat_wrap got count=%0d ops=%0d want count=1 ops=257", op_count, hs);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_reset_midop();
`ifdef MULT_ISSUE_STAT_EN
    test_stat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
